// File: rtl/muller_c_arbiter.sv
// rtl/muller_c_arbiter.sv - round-robin test controller for a shared Muller C-element
//
// Shares one asynchronous C-element between NUM_REQ requesters. Each grant
// runs one 4-phase cycle on the element: raise a/b, wait for q high, drop
// a/b, wait for q low. The requester then gets a done or err pulse.
//
// Optional feature macro: MULLER_C_ARB_STATS_EN (adds stat_ok / stat_err).
//
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   req       in   [NUM_REQ]  level requests, held until done/err
//   skew      in   [NUM_REQ]  1 = drive a one cycle before b for that requester
//   gnt       out  [NUM_REQ]  one-hot grant, held for the whole transaction
//   done      out  [NUM_REQ]  one-cycle pulse, transaction completed
//   err       out  [NUM_REQ]  one-cycle pulse, transaction timed out
//   busy      out  high whenever the FSM is not idle
//   c_a, c_b  out  registered drives of C-element inputs a and b
//   c_q       in   C-element output, asynchronous to clock
//   stat_ok   out  [16] saturating count of done pulses (stats build only)
//   stat_err  out  [16] saturating count of err pulses (stats build only)

module muller_c_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_W   = 8,
   parameter int TIMEOUT_CYC = 200,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] skew,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] err,
   output logic               busy,
   output logic               c_a,
   output logic               c_b,
   input  logic               c_q
`ifdef MULLER_C_ARB_STATS_EN
   ,
   output logic [15:0]        stat_ok,
   output logic [15:0]        stat_err
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IW1   = IDX_W + 1;

   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARM_A   = 3'd1;
   localparam logic [2:0] S_ARM_B   = 3'd2;
   localparam logic [2:0] S_WAIT_HI = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_WAIT_LO = 3'd5;
   localparam logic [2:0] S_FINISH  = 3'd6;

   logic [2:0]             state;
   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       winner;
   logic [TIMEOUT_W-1:0]   count;
   logic                   err_flag;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   q_s;

   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic [IW1-1:0]         cand;
   logic [IW1-1:0]         wsum;
   logic [IDX_W-1:0]       ptr_next;

   // c_q is asynchronous; only the last synchronizer stage is ever used.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], c_q};
      end
   end

   assign q_s  = sync_q[SYNC_STAGES-1];
   assign busy = (state != S_IDLE);

   // First set request at or after ptr, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr} + IW1'(i);
         if (cand >= IW1'(NUM_REQ)) begin
            cand = cand - IW1'(NUM_REQ);
         end
         if (!pick_found && req[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      wsum = {1'b0, winner} + IW1'(1);
      if (wsum >= IW1'(NUM_REQ)) begin
         wsum = '0;
      end
      ptr_next = wsum[IDX_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         ptr      <= '0;
         winner   <= '0;
         count    <= '0;
         err_flag <= 1'b0;
         gnt      <= '0;
         done     <= '0;
         err      <= '0;
         c_a      <= 1'b0;
         c_b      <= 1'b0;
      end else begin
         done <= '0;
         err  <= '0;
         // Element drives follow the current state through a register, so
         // a/b change one cycle after the state that commands them.
         c_a  <= (state == S_ARM_A) || (state == S_ARM_B) || (state == S_WAIT_HI);
         c_b  <= (state == S_ARM_B) || (state == S_WAIT_HI);

         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  winner <= pick_idx;
                  gnt    <= NUM_REQ'(1) << pick_idx;
                  state  <= skew[pick_idx] ? S_ARM_A : S_ARM_B;
               end
            end
            S_ARM_A: begin
               state <= S_ARM_B;
            end
            S_ARM_B: begin
               count <= '0;
               state <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (q_s) begin
                  state <= S_RELEASE;
               end else if (count == TO_LAST) begin
                  err_flag <= 1'b1;
                  state    <= S_RELEASE;
               end else if (count != '1) begin
                  count <= count + TIMEOUT_W'(1);
               end
            end
            S_RELEASE: begin
               count <= '0;
               state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               // The status pulse is launched on entry to FINISH so it is
               // visible while FINISH is the current state.
               if (!q_s) begin
                  state <= S_FINISH;
                  if (err_flag) begin
                     err[winner] <= 1'b1;
                  end else begin
                     done[winner] <= 1'b1;
                  end
               end else if (count == TO_LAST) begin
                  err_flag    <= 1'b1;
                  err[winner] <= 1'b1;
                  state       <= S_FINISH;
               end else if (count != '1) begin
                  count <= count + TIMEOUT_W'(1);
               end
            end
            S_FINISH: begin
               gnt      <= '0;
               err_flag <= 1'b0;
               ptr      <= ptr_next;
               state    <= S_IDLE;
            end
            default: begin
               gnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MULLER_C_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_ok  <= '0;
         stat_err <= '0;
      end else begin
         if (|done && stat_ok != 16'hFFFF) begin
            stat_ok <= stat_ok + 16'd1;
         end
         if (|err && stat_err != 16'hFFFF) begin
            stat_err <= stat_err + 16'd1;
         end
      end
   end
`endif

endmodule
